vec_alu_lanes: RTL and testbench

- Parametrised successor of the fixed four-lane vector ALU.
- Processes a vector of NUM_ELEM elements, each ELEM_W bits wide, using NUM_LANES physical lanes.
- The vector is processed over NUM_ELEM/NUM_LANES passes under a start/ready handshake.
- Adds logic ops, unsigned saturating add/sub, an illegal-op flag and a busy indication.
- Sits between the vector register file and the writeback stage of Vec_CPU.

---
 rtl/vec_alu_pkg.sv | 25 ++
 rtl/vec_alu_lane.sv | 18 +
 rtl/vec_alu_lanes.sv | 82 ++++++++
 tb/tb_vec_alu_lanes.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/vec_alu_pkg.sv
// vec_alu_pkg: opcodes, FSM states and saturating-arithmetic helpers shared by the vector ALU
package vec_alu_pkg;
    typedef enum logic [3:0] {
        OP_AND    = 4'b0000,
        OP_OR     = 4'b0001,
        OP_XOR    = 4'b0010,
        OP_ADD_VV = 4'b1010,
        OP_ADD_VS = 4'b1011,
        OP_SUB_VV = 4'b1100,
        OP_SUB_VS = 4'b1101,
        OP_SAT_ADD = 4'b1110,
        OP_SAT_SUB = 4'b1111
    } alu_op_e;
    typedef enum logic {IDLE, RUN} state_e;
    function automatic logic [63:0] sat_op(input logic [63:0] a, input logic [63:0] b, input int w, input logic sub);
        logic [64:0] s;
        logic [64:0] mx;
        mx = (65'd1 << w) - 65'd1;
        s = {1'b0, a} + {1'b0, b};
        return sub ? (a < b ? 64'd0 : a - b) : (s > mx ? mx[63:0] : s[63:0]);
    endfunction
    function automatic logic op_legal(input alu_op_e op);
        return op inside {OP_AND, OP_OR, OP_XOR, OP_ADD_VV, OP_ADD_VS, OP_SUB_VV, OP_SUB_VS, OP_SAT_ADD, OP_SAT_SUB};
    endfunction
endpackage

// File: rtl/vec_alu_lane.sv
// vec_alu_lane: combinational single-element ALU (op, a, b -> result; illegal op yields 0)
module vec_alu_lane import vec_alu_pkg::*; #(
    parameter int W = 8
) (
    input  alu_op_e        op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [W-1:0]   result
);
    always_comb
        result = op == OP_AND ? a & b :
                 op == OP_OR  ? a | b :
                 op == OP_XOR ? a ^ b :
                 op inside {OP_ADD_VV, OP_ADD_VS} ? a + b :
                 op inside {OP_SUB_VV, OP_SUB_VS} ? a - b :
                 op == OP_SAT_ADD ? W'(sat_op(64'(a), 64'(b), W, 1'b0)) :
                 op == OP_SAT_SUB ? W'(sat_op(64'(a), 64'(b), W, 1'b1)) : '0;
endmodule

// File: rtl/vec_alu_lanes.sv
// vec_alu_lanes: multi-pass vector ALU, NUM_LANES elements per cycle, start/rdy handshake, async active-low reset
module vec_alu_lanes import vec_alu_pkg::*; #(
    parameter  int ELEM_W    = 8,
    parameter  int NUM_ELEM  = 8,
    parameter  int NUM_LANES = 4,
    localparam int VW        = ELEM_W * NUM_ELEM
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_st,
    input  logic [3:0]        alu_op,
    input  logic [ELEM_W-1:0] esc,
    input  logic [VW-1:0]     vec1,
    input  logic [VW-1:0]     vec2,
    output logic              alu_busy,
    output logic              alu_rdy,
    output logic              op_err,
    output logic [VW-1:0]     vec_result
);
    localparam int P  = NUM_ELEM / NUM_LANES;
    localparam int GW = P > 1 ? $clog2(P) : 1;
    if (NUM_ELEM % NUM_LANES != 0) begin : g_chk
        $error("NUM_ELEM must be a multiple of NUM_LANES");
    end
    state_e            state, state_nxt;
    alu_op_e           op_q;
    logic [ELEM_W-1:0] esc_q;
    logic [VW-1:0]     a_q, b_q, acc, acc_nxt;
    logic [GW-1:0]     g;
    logic              last, vs;
    logic [ELEM_W-1:0] lane_res [NUM_LANES];
    assign last = g == GW'(P - 1);
    assign vs   = op_q inside {OP_ADD_VS, OP_SUB_VS};
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [ELEM_W-1:0] a, b;
        assign a = a_q[(int'(g) * NUM_LANES + i) * ELEM_W +: ELEM_W];
        assign b = vs ? esc_q : b_q[(int'(g) * NUM_LANES + i) * ELEM_W +: ELEM_W];
        vec_alu_lane #(.W(ELEM_W)) u_lane (.op(op_q), .a(a), .b(b), .result(lane_res[i]));
    end
    always_comb begin
        acc_nxt = acc;
        for (int i = 0; i < NUM_LANES; i++)
            acc_nxt[(int'(g) * NUM_LANES + i) * ELEM_W +: ELEM_W] = lane_res[i];
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    always_comb
        state_nxt = state == IDLE ? (alu_st ? RUN : IDLE) : (last ? IDLE : RUN);
    always_comb
        alu_busy = state == RUN;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q       <= OP_AND;
            esc_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc        <= '0;
            g          <= '0;
            alu_rdy    <= 1'b0;
            op_err     <= 1'b0;
            vec_result <= '0;
        end else begin
            alu_rdy <= state == RUN && last;
            if (state == IDLE && alu_st) begin
                op_q  <= alu_op_e'(alu_op);
                esc_q <= esc;
                a_q   <= vec1;
                b_q   <= vec2;
                g     <= '0;
            end
            if (state == RUN) begin
                acc <= acc_nxt;
                g   <= last ? '0 : g + GW'(1);
                if (last) begin
                    vec_result <= acc_nxt;
                    op_err     <= !op_legal(op_q);
                end
            end
        end
    end
endmodule

// File: tb/tb_vec_alu_lanes.sv
// tb_vec_alu_lanes: table-driven check of vec_alu_lanes plus handshake, reset and parameter-sweep sequences
module tb_vec_alu_lanes;
    typedef struct packed {
        logic [3:0]  op;
        logic [7:0]  esc;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        logic        err;
    } vec_t;
    logic clk = 0, reset = 1, alu_st = 0, st_s = 0, st16 = 0;
    logic [3:0]  alu_op = 0;
    logic [7:0]  esc = 0;
    logic [15:0] esc16 = 0;
    logic [63:0] vec1 = 0, vec2 = 0, a16 = 0, b16 = 0;
    logic busy, rdy, err, busy8, rdy8, err8, busy1, rdy1, err1, busy16, rdy16, err16;
    logic [63:0] res, res8, res1, res16;
    int n = 0, f = 0;
    vec_t tv [15];
    always #5 clk = ~clk;
    vec_alu_lanes dut (.clk(clk), .reset(reset), .alu_st(alu_st), .alu_op(alu_op), .esc(esc),
        .vec1(vec1), .vec2(vec2), .alu_busy(busy), .alu_rdy(rdy), .op_err(err), .vec_result(res));
    vec_alu_lanes #(.NUM_LANES(8)) u8 (.clk(clk), .reset(reset), .alu_st(st_s), .alu_op(alu_op), .esc(esc),
        .vec1(vec1), .vec2(vec2), .alu_busy(busy8), .alu_rdy(rdy8), .op_err(err8), .vec_result(res8));
    vec_alu_lanes #(.NUM_LANES(1)) u1 (.clk(clk), .reset(reset), .alu_st(st_s), .alu_op(alu_op), .esc(esc),
        .vec1(vec1), .vec2(vec2), .alu_busy(busy1), .alu_rdy(rdy1), .op_err(err1), .vec_result(res1));
    vec_alu_lanes #(.ELEM_W(16), .NUM_ELEM(4), .NUM_LANES(2)) u16 (.clk(clk), .reset(reset), .alu_st(st16),
        .alu_op(alu_op), .esc(esc16), .vec1(a16), .vec2(b16), .alu_busy(busy16), .alu_rdy(rdy16),
        .op_err(err16), .vec_result(res16));
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n++;
        if (act !== exp) begin
            f++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic run_op(input vec_t v, input int id);
        alu_op = v.op; esc = v.esc; vec1 = v.a; vec2 = v.b; alu_st = 1;
        tick;
        alu_st = 0;
        chk($sformatf("v%0d_busy0", id), 64'(busy), 64'd1);
        tick;
        chk($sformatf("v%0d_busy1", id), 64'(busy), 64'd1);
        chk($sformatf("v%0d_rdy1", id), 64'(rdy), 64'd0);
        tick;
        chk($sformatf("v%0d_rdy2", id), 64'(rdy), 64'd1);
        chk($sformatf("v%0d_busy2", id), 64'(busy), 64'd0);
        chk($sformatf("v%0d_res", id), res, v.exp);
        chk($sformatf("v%0d_err", id), 64'(err), 64'(v.err));
        tick;
        chk($sformatf("v%0d_rdy3", id), 64'(rdy), 64'd0);
    endtask
    initial begin
        tv[0]  = '{4'b1010, 8'h00, 64'h1122334455667788, 64'h1122334455667788, 64'h22446688AACCEE10, 1'b0};
        tv[1]  = '{4'b1101, 8'h22, 64'h0000000066220033, 64'h0, 64'hDEDEDEDE4400DE11, 1'b0};
        tv[2]  = '{4'b1011, 8'h22, 64'h0000000011220033, 64'h0, 64'h2222222233442255, 1'b0};
        tv[3]  = '{4'b1110, 8'h00, 64'hF0F0F0F0F0F0F0F0, 64'h2020202020202020, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        tv[4]  = '{4'b1111, 8'h00, 64'h1010101010101010, 64'h2020202020202020, 64'h0, 1'b0};
        tv[5]  = '{4'b1010, 8'h00, 64'hF0F0F0F0F0F0F0F0, 64'h2020202020202020, 64'h1010101010101010, 1'b0};
        tv[6]  = '{4'b0101, 8'h00, 64'h1122334455667788, 64'h1122334455667788, 64'h0, 1'b1};
        tv[7]  = '{4'b0000, 8'h00, 64'hFF00FF00F0F0F0F0, 64'h0FF00FF0FFFF0000, 64'h0F000F00F0F00000, 1'b0};
        tv[8]  = '{4'b0001, 8'h00, 64'h00FF00FF0F0F0000, 64'hF000000F00F0000F, 64'hF0FF00FF0FFF000F, 1'b0};
        tv[9]  = '{4'b0010, 8'h00, 64'hAAAAAAAA55555555, 64'hFFFF0000FFFF0000, 64'h5555AAAAAAAA5555, 1'b0};
        tv[10] = '{4'b1100, 8'h00, 64'h0102030405060708, 64'h0202020202020202, 64'hFF00010203040506, 1'b0};
        tv[11] = '{4'b1110, 8'h00, 64'h807F0100FE10C040, 64'h8001FF00010F403F, 64'hFF80FF00FF1FFF7F, 1'b0};
        tv[12] = '{4'b1111, 8'h00, 64'h0510FF00807F2001, 64'h061001017F801F00, 64'h0000FE0001000101, 1'b0};
        tv[13] = '{4'b1011, 8'hFF, 64'h0001020304050607, 64'h0, 64'hFF00010203040506, 1'b0};
        tv[14] = '{4'b0011, 8'h00, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0, 1'b1};
        #2 reset = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rdy", 64'(rdy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_res", res, 64'd0);
        reset = 1;
        @(negedge clk);
        for (int i = 0; i < 15; i++) run_op(tv[i], i);
        // start ignored while running
        alu_op = 4'b1010; vec1 = 64'h1122334455667788; vec2 = vec1; alu_st = 1;
        tick;
        alu_op = 4'b0010; vec1 = '1; vec2 = 0;
        tick;
        alu_st = 0;
        tick;
        chk("ign_rdy", 64'(rdy), 64'd1);
        chk("ign_res", res, 64'h22446688AACCEE10);
        tick;
        chk("ign_rdy_after", 64'(rdy), 64'd0);
        chk("ign_busy_after", 64'(busy), 64'd0);
        // start held high: one op every 3 cycles
        alu_op = 4'b1100; vec1 = 64'h0102030405060708; vec2 = 64'h0202020202020202; alu_st = 1;
        for (int k = 0; k < 9; k++) begin
            tick;
            chk($sformatf("b2b_rdy%0d", k), 64'(rdy), 64'(k % 3 == 2));
            if (k % 3 == 2) chk($sformatf("b2b_res%0d", k), res, 64'hFF00010203040506);
        end
        alu_st = 0;
        tick;
        tick;
        // asynchronous reset mid-operation
        alu_op = 4'b1010; vec1 = 64'h1122334455667788; vec2 = vec1; alu_st = 1;
        tick;
        alu_st = 0;
        tick;
        reset = 0;
        #1;
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_res", res, 64'd0);
        chk("ar_rdy", 64'(rdy), 64'd0);
        @(negedge clk);
        reset = 1;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk($sformatf("ar_norpy%0d", k), 64'(rdy), 64'd0);
        end
        run_op(tv[3], 100);
        // parameter sweep
        alu_op = 4'b1010; vec1 = 64'h1122334455667788; vec2 = vec1;
        a16 = 64'hFFFF000100020003; b16 = 64'h0001FFFF00010001; st_s = 1; st16 = 1;
        tick;
        st_s = 0; st16 = 0;
        chk("sw8_busy0", 64'(busy8), 64'd1);
        chk("sw16_busy0", 64'(busy16), 64'd1);
        for (int k = 1; k < 10; k++) begin
            tick;
            chk($sformatf("sw8_rdy%0d", k), 64'(rdy8), 64'(k == 1));
            chk($sformatf("sw1_rdy%0d", k), 64'(rdy1), 64'(k == 8));
            chk($sformatf("sw1_busy%0d", k), 64'(busy1), 64'(k < 8));
            chk($sformatf("sw16_rdy%0d", k), 64'(rdy16), 64'(k == 2));
            if (k == 1) begin
                chk("sw8_res", res8, 64'h22446688AACCEE10);
                chk("sw8_err", 64'(err8), 64'd0);
            end
            if (k == 2) begin
                chk("sw16_res", res16, 64'h0000000000030004);
                chk("sw16_err", 64'(err16), 64'd0);
            end
            if (k == 8) begin
                chk("sw1_res", res1, 64'h22446688AACCEE10);
                chk("sw1_err", 64'(err1), 64'd0);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n, f);
        $finish;
    end
endmodule
